// File: rtl/ahb_resp_mux.sv
// AHB-lite data-phase response multiplexer with a built-in default slave.
// The decoder's selects are captured at each accepted address phase. The
// captured select then steers read data, ready and response from the
// chosen slave back to the master. Unclaimed active transfers are answered
// by the default slave with the two-cycle ERROR response.
module ahb_resp_mux #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel_0,
  input  logic              hsel_1,
  input  logic              hsel_2,
  input  logic [1:0]        htrans,
  input  logic [DATA_W-1:0] hrdata_0,
  input  logic [DATA_W-1:0] hrdata_1,
  input  logic [DATA_W-1:0] hrdata_2,
  input  logic              hreadyout_0,
  input  logic              hreadyout_1,
  input  logic              hreadyout_2,
  input  logic              hresp_0,
  input  logic              hresp_1,
  input  logic              hresp_2,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic              hresp,
  output logic [1:0]        sel_slave
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned TRANS_W = 2;

  localparam logic [SEL_W-1:0]   SEL_S0      = SEL_W'(0);
  localparam logic [SEL_W-1:0]   SEL_S1      = SEL_W'(1);
  localparam logic [SEL_W-1:0]   SEL_S2      = SEL_W'(2);
  localparam logic [SEL_W-1:0]   SEL_DEFAULT = SEL_W'(3);

  localparam logic [TRANS_W-1:0] TRANS_NONSEQ = TRANS_W'(2);
  localparam logic [TRANS_W-1:0] TRANS_SEQ    = TRANS_W'(3);

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  ds_state_t        ds_state;
  ds_state_t        ds_next;
  logic [SEL_W-1:0] addr_code_c;
  logic             active_c;
  logic             slave_hready_c;
  logic             ds_hready_c;
  logic             ds_hresp_c;

  // Fixed-priority encode of the address-phase selects; nothing claimed -> default slave
  always_comb begin
    addr_code_c = SEL_DEFAULT;
    if (hsel_0) begin
      addr_code_c = SEL_S0;
    end else if (hsel_1) begin
      addr_code_c = SEL_S1;
    end else if (hsel_2) begin
      addr_code_c = SEL_S2;
    end
  end

  // Only NONSEQ and SEQ transfers need a real response; IDLE and BUSY get zero-wait OKAY
  always_comb begin
    active_c = (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
  end

  // Ready as seen while the default slave is idle. This keeps the FSM
  // transition free of a loop through its own ready output.
  always_comb begin
    slave_hready_c = 1'b1;
    case (sel_slave)
      SEL_S0:  slave_hready_c = hreadyout_0;
      SEL_S1:  slave_hready_c = hreadyout_1;
      SEL_S2:  slave_hready_c = hreadyout_2;
      default: slave_hready_c = 1'b1;
    endcase
  end

  // Data-phase select: loads on each accepted address phase, frozen through wait states
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_slave <= SEL_DEFAULT;
    end else if (hready) begin
      sel_slave <= addr_code_c;
    end
  end

  // Default-slave state register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      ds_state <= DS_IDLE;
    end else begin
      ds_state <= ds_next;
    end
  end

  // Default-slave next state and response: the ERROR is a wait cycle followed by a ready cycle
  always_comb begin
    ds_next     = ds_state;
    ds_hready_c = 1'b1;
    ds_hresp_c  = 1'b0;
    case (ds_state)
      DS_IDLE: begin
        if (slave_hready_c && (addr_code_c == SEL_DEFAULT) && active_c) begin
          ds_next = DS_ERR1;
        end
      end
      DS_ERR1: begin
        ds_hready_c = 1'b0;
        ds_hresp_c  = 1'b1;
        ds_next     = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp_c = 1'b1;
        if ((addr_code_c == SEL_DEFAULT) && active_c) begin
          ds_next = DS_ERR1;
        end else begin
          ds_next = DS_IDLE;
        end
      end
      default: begin
        ds_next = DS_IDLE;
      end
    endcase
  end

  // Response steering from the registered select; zero added latency
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    case (sel_slave)
      SEL_S0: begin
        hrdata = hrdata_0;
        hready = hreadyout_0;
        hresp  = hresp_0;
      end
      SEL_S1: begin
        hrdata = hrdata_1;
        hready = hreadyout_1;
        hresp  = hresp_1;
      end
      SEL_S2: begin
        hrdata = hrdata_2;
        hready = hreadyout_2;
        hresp  = hresp_2;
      end
      default: begin
        hrdata = '0;
        hready = ds_hready_c;
        hresp  = ds_hresp_c;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: slave steering, wait states, default-slave errors, reset.
module tb_ahb_resp_mux;

  localparam int unsigned DATA_W = 32;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              hsel_0, hsel_1, hsel_2;
  logic [1:0]        htrans;
  logic [DATA_W-1:0] hrdata_0, hrdata_1, hrdata_2;
  logic              hreadyout_0, hreadyout_1, hreadyout_2;
  logic              hresp_0, hresp_1, hresp_2;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;
  logic [1:0]        sel_slave;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_resp_mux #(.DATA_W(DATA_W)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hsel_0      (hsel_0),
    .hsel_1      (hsel_1),
    .hsel_2      (hsel_2),
    .htrans      (htrans),
    .hrdata_0    (hrdata_0),
    .hrdata_1    (hrdata_1),
    .hrdata_2    (hrdata_2),
    .hreadyout_0 (hreadyout_0),
    .hreadyout_1 (hreadyout_1),
    .hreadyout_2 (hreadyout_2),
    .hresp_0     (hresp_0),
    .hresp_1     (hresp_1),
    .hresp_2     (hresp_2),
    .hrdata      (hrdata),
    .hready      (hready),
    .hresp       (hresp),
    .sel_slave   (sel_slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input logic [2:0] sel, input logic [1:0] tr);
    hsel_0 = sel[0];
    hsel_1 = sel[1];
    hsel_2 = sel[2];
    htrans = tr;
  endtask

  // Sample all outputs mid-cycle on the falling edge
  task automatic expect_out(input string tag, input logic [1:0] sel, input logic rdy,
                            input logic rsp, input logic [DATA_W-1:0] data);
    @(negedge hclk);
    check({tag, ".sel"},    64'(sel_slave), 64'(sel));
    check({tag, ".hready"}, 64'(hready),    64'(rdy));
    check({tag, ".hresp"},  64'(hresp),     64'(rsp));
    check({tag, ".hrdata"}, 64'(hrdata),    64'(data));
  endtask

  initial begin
    // Reset held two edges with random inputs
    hreset      = 1'b1;
    hsel_0      = 1'($urandom);
    hsel_1      = 1'($urandom);
    hsel_2      = 1'($urandom);
    htrans      = 2'($urandom);
    hrdata_0    = $urandom;
    hrdata_1    = $urandom;
    hrdata_2    = $urandom;
    hreadyout_0 = 1'($urandom);
    hreadyout_1 = 1'($urandom);
    hreadyout_2 = 1'($urandom);
    hresp_0     = 1'($urandom);
    hresp_1     = 1'($urandom);
    hresp_2     = 1'($urandom);
    step();
    step();
    expect_out("rst", 2'd3, 1'b1, 1'b0, 32'h0);

    hreset      = 1'b0;
    addr(3'b000, T_IDLE);
    hrdata_0    = 32'hDEAD_0000;
    hrdata_1    = 32'hDEAD_1111;
    hrdata_2    = 32'hDEAD_2222;
    hreadyout_0 = 1'b1;
    hreadyout_1 = 1'b1;
    hreadyout_2 = 1'b1;
    hresp_0     = 1'b0;
    hresp_1     = 1'b0;
    hresp_2     = 1'b0;
    step();

    // Slave 1 read with two wait states; other slaves show contrasting values
    addr(3'b010, T_NONSEQ);
    step();
    addr(3'b000, T_IDLE);
    hrdata_1    = 32'hA5A5_0001;
    hreadyout_1 = 1'b0;
    hresp_0     = 1'b1;
    hresp_2     = 1'b1;
    expect_out("s1w0", 2'd1, 1'b0, 1'b0, 32'hA5A5_0001);
    step();
    expect_out("s1w1", 2'd1, 1'b0, 1'b0, 32'hA5A5_0001);
    step();
    hreadyout_1 = 1'b1;
    expect_out("s1d", 2'd1, 1'b1, 1'b0, 32'hA5A5_0001);
    step();
    hresp_0     = 1'b0;
    hresp_2     = 1'b0;
    expect_out("s1end", 2'd3, 1'b1, 1'b0, 32'h0);

    // Pipelined slave 0 then slave 2, zero wait
    addr(3'b001, T_NONSEQ);
    step();
    addr(3'b100, T_NONSEQ);
    hrdata_0    = 32'h1111_0000;
    hreadyout_1 = 1'b0;
    hreadyout_2 = 1'b0;
    hresp_1     = 1'b1;
    hresp_2     = 1'b1;
    expect_out("p0", 2'd0, 1'b1, 1'b0, 32'h1111_0000);
    step();
    addr(3'b000, T_IDLE);
    hrdata_2    = 32'h2222_0002;
    hreadyout_2 = 1'b1;
    hreadyout_0 = 1'b0;
    hresp_0     = 1'b1;
    hresp_2     = 1'b0;
    expect_out("p2", 2'd2, 1'b1, 1'b0, 32'h2222_0002);
    step();
    hreadyout_0 = 1'b1;
    hreadyout_1 = 1'b1;
    hresp_0     = 1'b0;
    hresp_1     = 1'b0;

    // Unmapped NONSEQ: two-cycle ERROR, then back to OKAY
    addr(3'b000, T_NONSEQ);
    expect_out("u_pre", 2'd3, 1'b1, 1'b0, 32'h0);
    step();
    addr(3'b000, T_IDLE);
    expect_out("u1", 2'd3, 1'b0, 1'b1, 32'h0);
    step();
    expect_out("u2", 2'd3, 1'b1, 1'b1, 32'h0);
    step();
    expect_out("u3", 2'd3, 1'b1, 1'b0, 32'h0);

    // Back-to-back unmapped transfers: no idle gap between errors
    addr(3'b000, T_NONSEQ);
    step();
    expect_out("b1", 2'd3, 1'b0, 1'b1, 32'h0);
    step();
    expect_out("b2", 2'd3, 1'b1, 1'b1, 32'h0);
    step();
    addr(3'b000, T_IDLE);
    expect_out("b3", 2'd3, 1'b0, 1'b1, 32'h0);
    step();
    expect_out("b4", 2'd3, 1'b1, 1'b1, 32'h0);
    step();
    expect_out("b5", 2'd3, 1'b1, 1'b0, 32'h0);

    // Unmapped BUSY after a slave 0 transfer: zero-wait OKAY
    addr(3'b001, T_NONSEQ);
    step();
    addr(3'b000, T_BUSY);
    expect_out("i0", 2'd0, 1'b1, 1'b0, 32'h1111_0000);
    step();
    addr(3'b000, T_IDLE);
    expect_out("i1", 2'd3, 1'b1, 1'b0, 32'h0);
    step();
    expect_out("i2", 2'd3, 1'b1, 1'b0, 32'h0);

    // Reset during the first error cycle suppresses the second
    addr(3'b000, T_NONSEQ);
    step();
    addr(3'b000, T_IDLE);
    expect_out("r1", 2'd3, 1'b0, 1'b1, 32'h0);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    expect_out("r2", 2'd3, 1'b1, 1'b0, 32'h0);
    step();
    expect_out("r3", 2'd3, 1'b1, 1'b0, 32'h0);

    // Reset in a slave wait state overrides the frozen select
    addr(3'b010, T_NONSEQ);
    step();
    addr(3'b000, T_IDLE);
    hreadyout_1 = 1'b0;
    expect_out("w1", 2'd1, 1'b0, 1'b0, 32'hA5A5_0001);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    expect_out("w2", 2'd3, 1'b1, 1'b0, 32'h0);
    hreadyout_1 = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
# ahb_resp_mux

AHB-lite data-phase response multiplexer and default slave, directly downstream of the address decoder. It registers the decoder's slave selects at each address-phase acceptance and steers the selected slave's read data, ready and response back to the master during the following data phase. Accesses that no decoder output claims (haddr[15:14] = 2'b11) are absorbed by an internal default slave that returns the two-cycle AHB ERROR response.

## Interface
- DATA_W, 32, width of read-data buses
- hclk  input  1  bus clock; all state updates on rising edge
- hreset  input  1  synchronous, active-high reset
- hsel_0 / hsel_1 / hsel_2  input  1 each  address-phase selects from decoder
- htrans  input  2  master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
- hrdata_0 / hrdata_1 / hrdata_2  input  DATA_W each  slave read data
- hreadyout_0 / hreadyout_1 / hreadyout_2  input  1 each  slave ready
- hresp_0 / hresp_1 / hresp_2  input  1 each  slave response (0 OKAY, 1 ERROR)
- hrdata  output  DATA_W  read data to master
- hready  output  1  combined ready to master and all slaves
- hresp  output  1  combined response to master
- sel_slave  output  2  registered data-phase select: 0,1,2 = slave, 3 = default slave

## Operation
- Address-phase select code: hsel_0 -> 0, else hsel_1 -> 1, else hsel_2 -> 2, else 3. Multiple hsel asserted is illegal; fixed priority 0 > 1 > 2 applies.
- sel_slave register: loads address-phase code on a rising edge where hready = 1; holds while hready = 0. Reset value 3.
- sel_slave = 0..2: hrdata/hready/hresp = hrdata_n/hreadyout_n/hresp_n (pure combinational pass-through of the registered selection).
- sel_slave = 3: hrdata = 0; hready/hresp driven by default-slave FSM.
- Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2. Reset to DS_IDLE.
  - DS_IDLE: hready = 1, hresp = 0. Edge with hready = 1, code = 3, htrans[1] = 1 -> DS_ERR1; otherwise stay.
  - DS_ERR1: hready = 0, hresp = 1. Next edge -> DS_ERR2 unconditionally.
  - DS_ERR2: hready = 1, hresp = 1. Next edge: if code = 3 and htrans[1] = 1 -> DS_ERR1; else -> DS_IDLE.
- IDLE/BUSY transfer to an unmapped address: sel_slave = 3, FSM stays DS_IDLE, zero-wait OKAY.
- FSM advances only while sel_slave = 3 or when entering it; transfers to real slaves leave FSM in DS_IDLE.
- Address phase presented during DS_ERR1 is not sampled (hready = 0); the master may change htrans to IDLE there, per AHB error rules.

## Timing
- Address phase at edge N (hready = 1) -> data phase begins after edge N; response steering is combinational from sel_slave, zero added latency.
- Slave wait states extend the data phase 1:1; sel_slave frozen throughout.
- Unmapped active transfer: exactly 2 data-phase cycles (hready 0 then 1, hresp 1 both cycles).
- Back-to-back unmapped active transfers: ERR1, ERR2, ERR1, ERR2; no DS_IDLE gap.
- Reset asserted at any edge, including mid-wait or DS_ERR1: after that edge sel_slave = 3, FSM = DS_IDLE, hready = 1, hresp = 0, hrdata = 0. Reset dominates all loads.
- Outputs after reset: hrdata = 0, hready = 1, hresp = 0, sel_slave = 3.

## Test plan
- Reset: hold hreset 2 cycles with random inputs -> hready = 1, hresp = 0, hrdata = 0, sel_slave = 3.
- Slave 1 read, 2 wait states: hsel_1 = 1, NONSEQ; hreadyout_1 = 0,0,1, hrdata_1 = 32'hA5A5_0001 -> sel_slave = 1 for 3 cycles, hready 0,0,1, hrdata = 32'hA5A5_0001 on final cycle.
- Pipelined slave 0 then slave 2: consecutive NONSEQ with hsel_0 then hsel_2, zero wait -> sel_slave 0 then 2 on consecutive cycles, hrdata follows hrdata_0 then hrdata_2.
- Unmapped NONSEQ (no hsel): -> sel_slave = 3, hready 0 then 1, hresp 1 both cycles, hrdata = 0; following IDLE -> hready 1, hresp 0.
- Unmapped IDLE transfer -> sel_slave = 3, single cycle hready = 1, hresp = 0, FSM stays DS_IDLE.
- Reset in DS_ERR1: assert hreset during first error cycle -> after edge hready = 1, hresp = 0, sel_slave = 3, no ERR2 cycle.
